// File: rtl/cla_pkg.sv
// Shared definitions for the CLA result stage: op encodings, adder bus widths and the
// layout of one queued result entry.
package cla_pkg;

  localparam int unsigned SUM_W = 9;
  localparam int unsigned IN_W  = 32;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ACC   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  // A queued entry is {acc[ACC_W-1:0], flags_t}; the accumulator width is per instance.
  typedef struct packed {
    logic carry8;
    logic zero;
    logic ovf;
  } flags_t;

  localparam int unsigned FLAGS_W = $bits(flags_t);

  function automatic flags_t make_flags(input logic carry8, input logic zero, input logic ovf);
    flags_t f;
    f.carry8 = carry8;
    f.zero   = zero;
    f.ovf    = ovf;
    return f;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Two-entry synchronous FIFO with 1-bit wrapping pointers. When empty, the read port
// keeps presenting the most recently popped entry (all zeros after reset).
module result_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // While empty, wr_ptr == rd_ptr, so the slot behind rd_ptr holds the last popped
  // entry and cannot be overwritten until the FIFO is non-empty again.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
    if (empty_o) begin
      rdata_o = mem_q[~rd_ptr_q];
    end
  end

endmodule

// File: rtl/cla_result_stage.sv
// Consumes the CLA sum bus, applies LOAD/ACC/CLEAR/NOP to an accumulator and queues
// {accumulator, flags} in a 2-entry FIFO for writeback.
module cla_result_stage #(
  parameter int unsigned SUM_W = cla_pkg::SUM_W,
  parameter int unsigned IN_W  = cla_pkg::IN_W,
  parameter int unsigned ACC_W = 32,  // SUM_W <= ACC_W <= IN_W
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  sum_i,
  input  logic [1:0]       op_i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_carry8,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_upper,
  output logic [CNT_W-1:0] op_cnt
);

  import cla_pkg::*;

  localparam int unsigned EntW = ACC_W + FLAGS_W;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             err_upper_q;
  logic             err_upper_d;
  logic [CNT_W-1:0] op_cnt_q;
  logic [CNT_W-1:0] op_cnt_d;
  logic             rdy_en_q;

  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W:0]   acc_add;
  logic             upper_nz;
  logic             accept;

  logic             fifo_push;
  logic             fifo_pop;
  logic [EntW-1:0]  push_entry;
  logic [EntW-1:0]  head_entry;
  logic [1:0]       fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_fifo_full;
  flags_t           push_flags;
  flags_t           head_flags;

  // Held low until the first edge after reset release, then gated by occupancy only.
  assign in_ready = rdy_en_q && (fifo_count < 2'd2);
  assign accept   = in_valid && in_ready;

  assign sum_ext  = ACC_W'(sum_i[SUM_W-1:0]);
  assign acc_add  = {1'b0, acc_q} + {1'b0, sum_ext};
  assign upper_nz = |(sum_i >> SUM_W);

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    err_upper_d = err_upper_q;
    op_cnt_d    = op_cnt_q;
    if (accept) begin
      case (op_e'(op_i))
        OP_LOAD: begin
          acc_d = sum_ext;
          ovf_d = 1'b0;
        end
        OP_ACC: begin
          acc_d = acc_add[ACC_W-1:0];
          ovf_d = ovf_q | acc_add[ACC_W];
        end
        OP_CLEAR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        default: begin
          acc_d = acc_q;
          ovf_d = ovf_q;
        end
      endcase
      err_upper_d = err_upper_q | upper_nz;
      if (op_cnt_q != '1) begin
        op_cnt_d = op_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      err_upper_q <= 1'b0;
      op_cnt_q    <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      err_upper_q <= err_upper_d;
      op_cnt_q    <= op_cnt_d;
      rdy_en_q    <= 1'b1;
    end
  end

  assign push_flags = make_flags(sum_i[SUM_W-1], (acc_d == '0), ovf_d);
  assign push_entry = {acc_d, push_flags};
  assign fifo_push  = accept;
  assign fifo_pop   = out_ready && !fifo_empty;

  result_fifo #(
    .Width (EntW)
  ) u_result_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign unused_fifo_full = fifo_full;

  assign head_flags = head_entry[FLAGS_W-1:0];
  assign out_data   = head_entry[EntW-1:FLAGS_W];
  assign out_carry8 = head_flags.carry8;
  assign out_zero   = head_flags.zero;
  assign out_ovf    = head_flags.ovf;
  assign out_valid  = !fifo_empty;

  assign err_upper  = err_upper_q;
  assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_cla_result_stage.sv
// Bench for cla_result_stage: a 32-bit and a 10-bit accumulator instance share stimulus;
// expected entries go through a scoreboard queue and are compared at each pop.
module tb_cla_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sum_i = '0;
  logic [1:0]  op_i = 2'b00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        rnd_en = 1'b0;

  logic        in_ready, out_carry8, out_zero, out_ovf, out_valid, err_upper;
  logic [31:0] out_data;
  logic [15:0] op_cnt;
  logic        in_ready_b, carry8_b, zero_b, ovf_b, valid_b, err_b;
  logic [9:0]  out_data_b;
  logic [15:0] op_cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d32;
    logic        c8;
    logic        z;
    logic        o32;
    logic [9:0]  d10;
    logic        o10;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] sum;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[14];

  cla_result_stage u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum_i      (sum_i),
    .op_i       (op_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_carry8 (out_carry8),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_upper  (err_upper),
    .op_cnt     (op_cnt)
  );

  cla_result_stage #(
    .ACC_W (10)
  ) u_dut10 (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum_i      (sum_i),
    .op_i       (op_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready_b),
    .out_data   (out_data_b),
    .out_carry8 (carry8_b),
    .out_zero   (zero_b),
    .out_ovf    (ovf_b),
    .out_valid  (valid_b),
    .out_ready  (out_ready),
    .err_upper  (err_b),
    .op_cnt     (op_cnt_b)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] d32, input logic c8, input logic z,
                              input logic o32, input logic [9:0] d10, input logic o10);
    exp_t e;
    e.d32 = d32;
    e.c8  = c8;
    e.z   = z;
    e.o32 = o32;
    e.d10 = d10;
    e.o10 = o10;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops happen at the next rising edge; outputs are stable here at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got out_data 0x%0h expected no entry", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("data32", out_data, mon_e.d32);
        check("carry8", out_carry8, mon_e.c8);
        check("zero", out_zero, mon_e.z);
        check("ovf32", out_ovf, mon_e.o32);
        check("data10", out_data_b, mon_e.d10);
        check("ovf10", ovf_b, mon_e.o10);
        check("valid10", valid_b, 1'b1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] sum, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    op_i     = op;
    sum_i    = sum;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd_en    = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_valid", out_valid, 1'b0);
    check("drain_sb", sb.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 32'h00F, mk(32'h00F, 1'b0, 1'b0, 1'b0, 10'h00F, 1'b0)};
    vecs[1]  = '{2'b01, 32'h0FF, mk(32'h10E, 1'b0, 1'b0, 1'b0, 10'h10E, 1'b0)};
    vecs[2]  = '{2'b10, 32'h000, mk(32'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0)};
    vecs[3]  = '{2'b00, 32'h1FE, mk(32'h1FE, 1'b1, 1'b0, 1'b0, 10'h1FE, 1'b0)};
    vecs[4]  = '{2'b01, 32'h1FE, mk(32'h3FC, 1'b1, 1'b0, 1'b0, 10'h3FC, 1'b0)};
    vecs[5]  = '{2'b01, 32'h1FE, mk(32'h5FA, 1'b1, 1'b0, 1'b0, 10'h1FA, 1'b1)};
    vecs[6]  = '{2'b11, 32'h055, mk(32'h5FA, 1'b0, 1'b0, 1'b0, 10'h1FA, 1'b1)};
    vecs[7]  = '{2'b01, 32'h000, mk(32'h5FA, 1'b0, 1'b0, 1'b0, 10'h1FA, 1'b1)};
    vecs[8]  = '{2'b01, 32'h1FE, mk(32'h7F8, 1'b1, 1'b0, 1'b0, 10'h3F8, 1'b1)};
    vecs[9]  = '{2'b10, 32'h1FF, mk(32'h000, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0)};
    vecs[10] = '{2'b01, 32'h1FF, mk(32'h1FF, 1'b1, 1'b0, 1'b0, 10'h1FF, 1'b0)};
    vecs[11] = '{2'b01, 32'h1FF, mk(32'h3FE, 1'b1, 1'b0, 1'b0, 10'h3FE, 1'b0)};
    vecs[12] = '{2'b01, 32'h1FF, mk(32'h5FD, 1'b1, 1'b0, 1'b0, 10'h1FD, 1'b1)};
    vecs[13] = '{2'b00, 32'h003, mk(32'h003, 1'b0, 1'b0, 1'b0, 10'h003, 1'b0)};

    // Reset state
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_flags", {out_carry8, out_zero, out_ovf}, 3'b000);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_cnt", op_cnt, 16'd0);
    check("rst_err", err_upper, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", in_ready, 1'b1);

    // First LOAD: visible one edge after accept
    out_ready = 1'b0;
    send(2'b00, 32'h100, mk(32'h100, 1'b1, 1'b0, 1'b0, 10'h100, 1'b0));
    check("lat_valid", out_valid, 1'b1);
    check("lat_data", out_data, 32'h100);
    check("lat_carry8", out_carry8, 1'b1);
    check("lat_zero", out_zero, 1'b0);
    check("lat_cnt", op_cnt, 16'd1);

    // Table of op sequences under random output backpressure
    rnd_en = 1'b1;
    foreach (vecs[i]) send(vecs[i].op, vecs[i].sum, vecs[i].e);
    drain();
    check("tbl_cnt32", op_cnt, 16'd15);
    check("tbl_cnt10", op_cnt_b, 16'd15);
    check("tbl_err", err_upper, 1'b0);
    check("empty_hold", out_data, 32'h003);

    // Backpressure: two accepts fill the FIFO, the third waits for a pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_i      = 2'b00;
    sum_i     = 32'h011;
    @(negedge clk);
    check("bp_rdy0", in_ready, 1'b1);
    sb.push_back(mk(32'h011, 1'b0, 1'b0, 1'b0, 10'h011, 1'b0));
    @(posedge clk);
    #1;
    sum_i = 32'h022;
    @(negedge clk);
    check("bp_rdy1", in_ready, 1'b1);
    sb.push_back(mk(32'h022, 1'b0, 1'b0, 1'b0, 10'h022, 1'b0));
    @(posedge clk);
    #1;
    sum_i = 32'h033;
    @(negedge clk);
    check("bp_full", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_hold_rdy", in_ready, 1'b0);
    check("bp_hold_head", out_data, 32'h011);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_edge_rdy", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_freed", in_ready, 1'b1);
    sb.push_back(mk(32'h033, 1'b0, 1'b0, 1'b0, 10'h033, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Upper bits: flagged sticky, ignored for data
    check("err_pre", err_upper, 1'b0);
    send(2'b00, 32'h0000_0200, mk(32'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0));
    check("err_set", err_upper, 1'b1);
    check("err_set10", err_b, 1'b1);
    send(2'b00, 32'h005, mk(32'h005, 1'b0, 1'b0, 1'b0, 10'h005, 1'b0));
    check("err_sticky", err_upper, 1'b1);
    drain();

    // Reset with two queued entries
    out_ready = 1'b0;
    send(2'b00, 32'h0AA, mk(32'h0AA, 1'b0, 1'b0, 1'b0, 10'h0AA, 1'b0));
    send(2'b00, 32'h0BB, mk(32'h0BB, 1'b0, 1'b0, 1'b0, 10'h0BB, 1'b0));
    check("mid_valid_pre", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", out_valid, 1'b0);
    check("mid_data", out_data, 32'h0);
    check("mid_in_ready", in_ready, 1'b0);
    check("mid_cnt", op_cnt, 16'd0);
    check("mid_err", err_upper, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_in_ready", in_ready, 1'b1);
    check("post_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    send(2'b01, 32'h001, mk(32'h001, 1'b0, 1'b0, 1'b0, 10'h001, 1'b0));
    check("post_cnt", op_cnt, 16'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_result_stage.md
Name: cla_result_stage

Overview:
- Downstream consumer of the 8-bit carry-lookahead adder's 32-bit sum bus; only bits [8:0] carry data, and bit 8 is the carry-out.
- Accepts one sum per valid/ready handshake and applies an op: LOAD, ACC (accumulate) or CLEAR.
- Derives status flags and queues {accumulator, flags} in a 2-entry output FIFO for the processor datapath / register writeback.

Parameters:
- SUM_W, 9, meaningful adder result bits (8 sum + carry).
- IN_W, 32, width of the adder's output bus.
- ACC_W, 32, accumulator width; legal range SUM_W <= ACC_W <= IN_W.
- CNT_W, 16, width of the saturating accepted-op counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sum_i  in  IN_W  sum bus from the adder.
- op_i  in  2  00 LOAD, 01 ACC, 10 CLEAR, 11 reserved (NOP).
- in_valid  in  1  sum_i/op_i valid.
- in_ready  out  1  stage can accept.
- out_data  out  ACC_W  accumulator value at the head of the FIFO.
- out_carry8  out  1  sum_i[8] of the op that produced the head entry.
- out_zero  out  1  head accumulator value == 0.
- out_ovf  out  1  sticky accumulator overflow, as captured for the head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes the head entry.
- err_upper  out  1  sticky: an accepted sum_i had nonzero bits [IN_W-1:SUM_W].
- op_cnt  out  CNT_W  accepted-op count, saturating.

Behaviour:
- Reset (async, immediate on rst_n low):
  - accumulator 0, FIFO emptied, ovf 0, err_upper 0, op_cnt 0.
  - out_valid 0, out_data 0, out_carry8 0, out_zero 0, out_ovf 0, in_ready 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-transfer drops all queued entries; no partial output.
- Input handshake:
  - Transfer occurs at a rising edge with in_valid && in_ready.
  - in_ready = (fifo_count < 2), combinational from registered count only; it does not depend on out_ready.
  - Producer holds sum_i/op_i stable while in_valid && !in_ready.
- Op semantics on accept, using s = zero-extended sum_i[SUM_W-1:0]:
  - LOAD: acc <= s; ovf <= 0.
  - ACC: {c, acc} <= acc + s at ACC_W+1 bits; ovf <= ovf | c. The result wraps modulo 2^ACC_W.
  - CLEAR: acc <= 0; ovf <= 0; sum_i is ignored except for err_upper.
  - NOP (11): acc and ovf unchanged; an entry is still pushed and counted.
- Every accepted op:
  - Pushes {new acc, sum_i[8], new acc==0, new ovf}.
  - op_cnt increments and saturates at 2^CNT_W-1.
  - err_upper is set if sum_i[IN_W-1:SUM_W] != 0; it is cleared only by reset.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N; 1 cycle, no bypass.
- Output:
  - out_* fields reflect the FIFO head and are stable while out_valid && !out_ready.
  - A pop occurs at an edge with out_valid && out_ready.
- FIFO boundaries:
  - Full (count 2): in_ready=0; a pop at that edge frees a slot, and in_ready=1 in the next cycle.
  - Empty: out_valid=0; out_ready is ignored; out_* hold the last popped values (0 after reset).
  - Simultaneous push and pop with count 1: count stays 1 and the head advances to the new entry.
  - Pointers are 1 bit and wrap.

Decomposition:
- Package cla_pkg holds:
  - op encodings OP_LOAD/OP_ACC/OP_CLEAR/OP_NOP;
  - SUM_W, IN_W;
  - the packed result-entry layout {acc, carry8, zero, ovf}.
- Sub-module result_fifo: 2-entry synchronous FIFO, parameterised width, async active-low reset, exposing count/full/empty.

Test Plan:
- Reset then LOAD sum_i=0x100 (255+1) -> after 1 edge out_valid=1, out_data=0x100, out_carry8=1, out_zero=0, op_cnt=1.
- LOAD 0x00F, ACC 0x0FF, CLEAR -> entries in order 0x00F, 0x10E (carry8=0), 0x000 (zero=1, ovf=0).
- ACC_W=10: LOAD 0x1FE, ACC 0x1FE, ACC 0x1FE -> 0x1FE, 0x3FC, 0x1FA with out_ovf=0,0,1; ovf stays 1 until LOAD/CLEAR.
- Backpressure with out_ready=0 and 3 back-to-back valid inputs -> in_ready falls after 2 accepts; the 3rd is held and accepted the cycle after the first pop; order is preserved.
- sum_i=0x0000_0200 accepted -> err_upper=1 sticky; out_data uses only bits [8:0] (=0x000).
- rst_n pulsed low mid-cycle with 2 queued entries -> out_valid=0 immediately; after release, the queue is empty, acc=0 and op_cnt=0.
